// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared types and defaults for the hazard scoreboard.
//   sb_entry_t  : one in-flight destination write {v, dest, ld}.
//   FWD_RF      : forwarding select value meaning "read the register file".
//   *_DEF       : default parameter values for hazard_scoreboard.
//   Optional feature macro used by the top level: HAZARD_STATS_EN.
package hazard_pkg;

    localparam int REG_W_DEF   = 4;
    localparam int NUM_SRC_DEF = 3;
    localparam int DEPTH_DEF   = 2;

    // Entries carry a fixed-width dest field so the struct can live in the
    // package; narrower register addresses are zero-extended into it.
    // REG_W of any instance must not exceed REG_W_MAX.
    localparam int REG_W_MAX = 8;

    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                 v;
        logic [REG_W_MAX-1:0] dest;
        logic                 ld;
    } sb_entry_t;

endpackage

// File: rtl/hazard_src_match.sv
// hazard_src_match
//   Compares one source operand against every scoreboard entry and reports
//   the youngest (lowest-index) match.
//   Ports:
//     i_id_valid       ID stage holds a real instruction
//     i_src_valid      this operand is actually read
//     i_src            source register number
//     i_sb             scoreboard, entry 0 = EXE (youngest)
//     o_match_any      some valid entry writes this source
//     o_youngest_idx   index of the youngest matching entry
//     o_youngest_is_ld that youngest entry is a load
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic                  i_id_valid,
    input  logic                  i_src_valid,
    input  logic [REG_W-1:0]      i_src,
    input  sb_entry_t [DEPTH-1:0] i_sb,
    output logic                  o_match_any,
    output logic [SEL_W-1:0]      o_youngest_idx,
    output logic                  o_youngest_is_ld
);

    logic [REG_W_MAX-1:0] w_src_ext;

    assign w_src_ext = REG_W_MAX'(i_src);

    // Walk from oldest to youngest so the last hit (lowest k) wins.
    always_comb begin
        o_match_any      = 1'b0;
        o_youngest_idx   = '0;
        o_youngest_is_ld = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (i_sb[k].v && i_id_valid && i_src_valid && (i_sb[k].dest == w_src_ext)) begin
                o_match_any      = 1'b1;
                o_youngest_idx   = SEL_W'(k);
                o_youngest_is_ld = i_sb[k].ld;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   ID-stage hazard detector that tracks in-flight destination writes in its
//   own shift-register scoreboard (entry 0 = EXE, entry 1 = MEM, ...), so no
//   dest/wb/load signals are needed from later stages.
//   Ports:
//     clk, rst         clock, synchronous active-high reset
//     forward_en       1 = forward results, stall only on load-use
//     id_valid         ID holds a real instruction
//     id_src           NUM_SRC packed source registers, source i at [i*REG_W +: REG_W]
//     id_src_valid     per-source "operand is read"
//     id_dest          destination of the ID instruction
//     id_wb_en         ID instruction writes id_dest
//     id_mem_r_en      ID instruction is a load
//     freeze           hold all state (memory busy)
//     flush            kill the ID instruction (branch taken)
//     hazard_detected  stall IF/ID, bubble into EXE (combinational)
//     fwd_sel          per-source select: 0 = register file, k+1 = entry k (combinational)
//     inflight         registered count of valid scoreboard entries
//     stall_cycles     (HAZARD_STATS_EN only) saturating count of stalled cycles
//     ld_use_stalls    (HAZARD_STATS_EN only) saturating count of load-use stalls
//   Optional feature macro: HAZARD_STATS_EN.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_W   = REG_W_DEF,
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       forward_en,
    input  logic                       id_valid,
    input  logic [NUM_SRC*REG_W-1:0]   id_src,
    input  logic [NUM_SRC-1:0]         id_src_valid,
    input  logic [REG_W-1:0]           id_dest,
    input  logic                       id_wb_en,
    input  logic                       id_mem_r_en,
    input  logic                       freeze,
    input  logic                       flush,
    output logic                       hazard_detected,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
`ifdef HAZARD_STATS_EN
    output logic [15:0]                stall_cycles,
    output logic [15:0]                ld_use_stalls,
`endif
    output logic [SEL_W-1:0]           inflight
);

    sb_entry_t [DEPTH-1:0] r_sb;
    sb_entry_t [DEPTH-1:0] w_sb_next;
    sb_entry_t             w_new_entry;
    logic [SEL_W-1:0]      r_inflight;
    logic [SEL_W-1:0]      w_inflight_next;

    logic [NUM_SRC-1:0]    w_match_any;
    logic [NUM_SRC-1:0]    w_youngest_ld;
    logic [SEL_W-1:0]      w_youngest_idx [NUM_SRC];
    logic [NUM_SRC-1:0]    w_ld_use;
    logic [NUM_SRC-1:0]    w_src_hazard;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_src_match #(
            .REG_W (REG_W),
            .DEPTH (DEPTH),
            .SEL_W (SEL_W)
        ) u_match (
            .i_id_valid       (id_valid),
            .i_src_valid      (id_src_valid[i]),
            .i_src            (id_src[i*REG_W +: REG_W]),
            .i_sb             (r_sb),
            .o_match_any      (w_match_any[i]),
            .o_youngest_idx   (w_youngest_idx[i]),
            .o_youngest_is_ld (w_youngest_ld[i])
        );

        // Only a load still in EXE cannot be forwarded in time.
        assign w_ld_use[i]     = w_match_any[i] && (w_youngest_idx[i] == '0) && w_youngest_ld[i];
        assign w_src_hazard[i] = forward_en ? w_ld_use[i] : w_match_any[i];

        assign fwd_sel[i*SEL_W +: SEL_W] = (forward_en && w_match_any[i])
                                         ? SEL_W'(w_youngest_idx[i] + SEL_W'(1))
                                         : SEL_W'(FWD_RF);
    end

    assign hazard_detected = |w_src_hazard;

    // A stalled or flushed instruction enters EXE as a bubble.
    always_comb begin
        w_new_entry.v    = id_valid && id_wb_en && !hazard_detected && !flush;
        w_new_entry.dest = REG_W_MAX'(id_dest);
        w_new_entry.ld   = id_mem_r_en;
    end

    always_comb begin
        w_sb_next    = r_sb;
        w_sb_next[0] = w_new_entry;
        for (int k = 1; k < DEPTH; k++) begin
            w_sb_next[k] = r_sb[k-1];
        end
    end

    always_comb begin
        w_inflight_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_inflight_next = w_inflight_next + SEL_W'(w_sb_next[k].v);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb       <= '0;
            r_inflight <= '0;
        end else if (!freeze) begin
            r_sb       <= w_sb_next;
            r_inflight <= w_inflight_next;
        end
    end

    assign inflight = r_inflight;

`ifdef HAZARD_STATS_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_ld_use_stalls;
    logic        w_ld_use_stall;

    assign w_ld_use_stall = hazard_detected && (|w_ld_use);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles  <= '0;
            r_ld_use_stalls <= '0;
        end else if (!freeze) begin
            if (hazard_detected && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if (w_ld_use_stall && (r_ld_use_stalls != 16'hFFFF)) begin
                r_ld_use_stalls <= r_ld_use_stalls + 16'd1;
            end
        end
    end

    assign stall_cycles  = r_stall_cycles;
    assign ld_use_stalls = r_ld_use_stalls;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        forward_en;
    logic        id_valid;
    logic [11:0] id_src;
    logic [2:0]  id_src_valid;
    logic [3:0]  id_dest;
    logic        id_wb_en;
    logic        id_mem_r_en;
    logic        freeze;
    logic        flush;
    logic        hazard_detected;
    logic [5:0]  fwd_sel;
    logic [1:0]  inflight;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles;
    logic [15:0] ld_use_stalls;
`endif

    int n_checks = 0;
    int n_errors = 0;

    hazard_scoreboard #(
        .REG_W   (4),
        .NUM_SRC (3),
        .DEPTH   (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .forward_en      (forward_en),
        .id_valid        (id_valid),
        .id_src          (id_src),
        .id_src_valid    (id_src_valid),
        .id_dest         (id_dest),
        .id_wb_en        (id_wb_en),
        .id_mem_r_en     (id_mem_r_en),
        .freeze          (freeze),
        .flush           (flush),
        .hazard_detected (hazard_detected),
        .fwd_sel         (fwd_sel),
`ifdef HAZARD_STATS_EN
        .stall_cycles    (stall_cycles),
        .ld_use_stalls   (ld_use_stalls),
`endif
        .inflight        (inflight)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive_id(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                            input logic [3:0] s2, input logic [2:0] sv, input logic [3:0] d,
                            input logic wb, input logic ld);
        id_valid     = v;
        id_src       = {s2, s1, s0};
        id_src_valid = sv;
        id_dest      = d;
        id_wb_en     = wb;
        id_mem_r_en  = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle(input int n);
        drive_id(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst        = 1'b1;
        forward_en = 1'b1;
        freeze     = 1'b0;
        flush      = 1'b0;
        drive_id(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        drive_id(1'b1, 4'd1, 4'd2, 4'd3, 3'b111, 4'd0, 1'b0, 1'b0);
        settle();
        check_eq("rst_haz", hazard_detected, 0);
        check_eq("rst_fwd", fwd_sel, 0);
        check_eq("rst_infl", inflight, 0);
        tick();

        // ALU dependence with forwarding
        drive_id(1'b1, 4'd8, 4'd9, 4'd10, 3'b111, 4'd1, 1'b1, 1'b0);
        settle();
        check_eq("alu_issue_haz", hazard_detected, 0);
        tick();
        drive_id(1'b1, 4'd1, 4'd9, 4'd10, 3'b111, 4'd12, 1'b0, 1'b0);
        settle();
        check_eq("alu_e0_haz", hazard_detected, 0);
        check_eq("alu_e0_fwd", fwd_sel, 6'h01);
        check_eq("alu_e0_infl", inflight, 1);
        tick();
        drive_id(1'b1, 4'd9, 4'd10, 4'd1, 3'b111, 4'd12, 1'b0, 1'b0);
        settle();
        check_eq("alu_e1_haz", hazard_detected, 0);
        check_eq("alu_e1_fwd", fwd_sel, 6'h20);
        idle(2);

        // Load-use with forwarding: one stall cycle, then forward from MEM
        drive_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd4, 1'b1, 1'b1);
        settle();
        tick();
        drive_id(1'b1, 4'd5, 4'd4, 4'd6, 3'b111, 4'd13, 1'b1, 1'b0);
        settle();
        check_eq("lu_stall_haz", hazard_detected, 1);
        check_eq("lu_stall_infl", inflight, 1);
        tick();
        settle();
        check_eq("lu_after_haz", hazard_detected, 0);
        check_eq("lu_after_fwd", fwd_sel, 6'h08);
        check_eq("lu_after_infl", inflight, 1);
        idle(2);

        // Forwarding disabled: stall until producer leaves entry DEPTH-1
        forward_en = 1'b0;
        drive_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd5, 1'b1, 1'b0);
        settle();
        tick();
        drive_id(1'b1, 4'd5, 4'd11, 4'd12, 3'b111, 4'd2, 1'b0, 1'b0);
        settle();
        check_eq("off_c1_haz", hazard_detected, 1);
        check_eq("off_c1_fwd", fwd_sel, 0);
        tick();
        settle();
        check_eq("off_c2_haz", hazard_detected, 1);
        check_eq("off_c2_fwd", fwd_sel, 0);
        tick();
        settle();
        check_eq("off_c3_haz", hazard_detected, 0);
        check_eq("off_c3_fwd", fwd_sel, 0);
        forward_en = 1'b1;
        idle(2);

        // Freeze holds a load-use stall and the scoreboard
        drive_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd6, 1'b1, 1'b1);
        settle();
        tick();
        drive_id(1'b1, 4'd6, 4'd0, 4'd0, 3'b001, 4'd3, 1'b0, 1'b0);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq("frz_haz", hazard_detected, 1);
            check_eq("frz_infl", inflight, 1);
            tick();
        end
        freeze = 1'b0;
        settle();
        check_eq("unfrz_haz", hazard_detected, 1);
        tick();
        settle();
        check_eq("frz_post_haz", hazard_detected, 0);
        check_eq("frz_post_fwd", fwd_sel, 6'h02);
        check_eq("frz_post_infl", inflight, 1);

        // Flush turns a writing instruction into a bubble
        drive_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd14, 1'b1, 1'b0);
        flush = 1'b1;
        settle();
        tick();
        flush = 1'b0;
        drive_id(1'b1, 4'd14, 4'd0, 4'd0, 3'b001, 4'd0, 1'b0, 1'b0);
        settle();
        check_eq("flush_infl", inflight, 0);
        check_eq("flush_fwd", fwd_sel, 0);
        check_eq("flush_haz", hazard_detected, 0);
        idle(2);

        // Youngest writer wins; masked source and invalid ID never match
        drive_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd7, 1'b1, 1'b0);
        settle();
        tick();
        drive_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd7, 1'b1, 1'b0);
        settle();
        tick();
        drive_id(1'b1, 4'd0, 4'd7, 4'd0, 3'b010, 4'd0, 1'b0, 1'b0);
        settle();
        check_eq("yw_fwd", fwd_sel, 6'h04);
        check_eq("yw_haz", hazard_detected, 0);
        check_eq("yw_infl", inflight, 2);
        drive_id(1'b1, 4'd0, 4'd7, 4'd0, 3'b101, 4'd0, 1'b0, 1'b0);
        settle();
        check_eq("yw_masked_fwd", fwd_sel, 0);
        forward_en = 1'b0;
        drive_id(1'b0, 4'd7, 4'd7, 4'd7, 3'b111, 4'd0, 1'b0, 1'b0);
        settle();
        check_eq("yw_novalid_haz", hazard_detected, 0);
        check_eq("yw_novalid_fwd", fwd_sel, 0);
        forward_en = 1'b1;
        idle(2);

        // Reset mid-operation leaves no residual hazard
        drive_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd8, 1'b1, 1'b1);
        settle();
        tick();
        drive_id(1'b1, 4'd0, 4'd0, 4'd8, 3'b100, 4'd0, 1'b0, 1'b0);
        settle();
        check_eq("rm_pre_haz", hazard_detected, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check_eq("rm_haz", hazard_detected, 0);
        check_eq("rm_fwd", fwd_sel, 0);
        check_eq("rm_infl", inflight, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
